// File: rtl/i2c_slave_controller_pkg.sv
// Shared I2C definitions: bus field widths and the slave controller state encoding.
// The slave timer imports this package as well.
package i2c_slave_controller_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_RX,
    ADDR_ACK,
    DATA_RX,
    DATA_ACK,
    DATA_TX,
    TX_ACKCHK,
    WAIT_STOP
  } state_t;

  function automatic logic is_busy(state_t s);
    return !(s == IDLE || s == WAIT_STOP);
  endfunction

endpackage

// File: rtl/i2c_slave_controller.sv
// I2C slave byte-level controller: address match, write receive with ACK/NACK,
// read transmit with master ACK check. Bit timing comes from the external slave timer.
module i2c_slave_controller
  import i2c_slave_controller_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h2A
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              stop,
  input  logic              rising_edge,
  input  logic              falling_edge,
  input  logic              byte_received,
  input  logic              ack_prep,
  input  logic              ack_check,
  input  logic              ack_done,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              sda_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_full,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rx_shift_q, tx_shift_q, rx_data_q;
  logic [2:0]          bit_cnt_q;
  logic                rw_q, ack_q;
  logic                ack_prep_q, ack_check_q;
  logic                sda_out_q, sda_oe_q, rx_valid_q, tx_req_q, busy_q;
  logic                prep_first, check_first, addr_match;

  assign prep_first  = ack_prep & ~ack_prep_q;
  assign check_first = ack_check & ~ack_check_q;
  assign addr_match  = (rx_shift_q[DATA_W-1:1] == SLAVE_ADDR);

  // ack_q means "we ACKed" in DATA_ACK and "master ACKed" in TX_ACKCHK.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR_RX;
    end else begin
      case (state_q)
        ADDR_RX:   if (prep_first) state_d = addr_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  if (ack_done) state_d = rw_q ? DATA_TX : DATA_RX;
        DATA_RX:   if (prep_first) state_d = DATA_ACK;
        DATA_ACK:  if (ack_done) state_d = ack_q ? DATA_RX : WAIT_STOP;
        DATA_TX:   if (falling_edge && bit_cnt_q == 3'd7) state_d = TX_ACKCHK;
        TX_ACKCHK: begin
          if (check_first && sda_in) state_d = WAIT_STOP;
          else if (ack_done && ack_q) state_d = DATA_TX;
        end
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      ack_prep_q  <= 1'b0;
      ack_check_q <= 1'b0;
      sda_out_q   <= 1'b1;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ack_prep_q  <= ack_prep;
      ack_check_q <= ack_check;
      state_q     <= state_d;
      busy_q      <= is_busy(state_d);
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      if (stop) begin
        sda_oe_q  <= 1'b0;
        sda_out_q <= 1'b1;
      end else if (start) begin
        rx_shift_q <= '0;
        bit_cnt_q  <= '0;
        sda_oe_q   <= 1'b0;
        sda_out_q  <= 1'b1;
      end else begin
        case (state_q)
          ADDR_RX, DATA_RX: begin
            if (rising_edge && !byte_received)
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], sda_in};
            if (prep_first && state_q == ADDR_RX) begin
              rw_q <= rx_shift_q[0];
              if (addr_match) begin
                sda_oe_q  <= 1'b1;
                sda_out_q <= 1'b0;
              end
            end
            if (prep_first && state_q == DATA_RX) begin
              ack_q <= !rx_full;
              if (!rx_full) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_shift_q;
                sda_oe_q   <= 1'b1;
                sda_out_q  <= 1'b0;
              end
            end
          end
          ADDR_ACK, DATA_ACK, TX_ACKCHK: begin
            if (state_q == TX_ACKCHK && check_first) begin
              ack_q <= !sda_in;
            end else if (ack_done) begin
              if (state_d == DATA_TX) begin
                tx_shift_q <= tx_data;
                tx_req_q   <= 1'b1;
                bit_cnt_q  <= '0;
                sda_out_q  <= tx_data[DATA_W-1];
                sda_oe_q   <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                sda_out_q <= 1'b1;
              end
            end
          end
          DATA_TX: begin
            if (falling_edge) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q  <= 1'b0;
                sda_out_q <= 1'b1;
                ack_q     <= 1'b0;
              end else begin
                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                sda_out_q  <= tx_shift_q[DATA_W-2];
              end
            end
          end
          default: begin
            sda_oe_q  <= 1'b0;
            sda_out_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_out  = sda_out_q;
  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Self-checking bench for i2c_slave_controller: table of write transactions plus
// hand-written read, repeated-start, start/stop collision and mid-transfer reset sequences.
module tb_i2c_slave_controller;
  import i2c_slave_controller_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start, stop, rising_edge, falling_edge;
  logic       byte_received, ack_prep, ack_check, ack_done;
  logic       sda_in, sda_out, sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_full;
  logic [7:0] tx_data;
  logic       tx_req, busy;

  int compared   = 0;
  int mismatched = 0;
  int rxValidCnt = 0;
  int txReqCnt   = 0;
  logic oeEver   = 1'b0;

  typedef struct {
    logic [7:0] addrByte;
    logic [7:0] dataByte;
    logic       full;
    logic       expAddrAck;
    logic       expDataAck;
    int         expValid;
    logic [7:0] expRxData;
    state_t     expState;
  } vec_t;

  vec_t vecs[6];

  i2c_slave_controller #(.SLAVE_ADDR(7'h2A)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stop(stop),
    .rising_edge(rising_edge), .falling_edge(falling_edge),
    .byte_received(byte_received), .ack_prep(ack_prep), .ack_check(ack_check),
    .ack_done(ack_done), .sda_in(sda_in), .sda_out(sda_out), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters and drive observation, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid) rxValidCnt++;
    if (tx_req)   txReqCnt++;
    if (sda_oe)   oeEver = 1'b1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sendStart();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic sendStop();
    stop = 1'b1; tick(); stop = 1'b0; tick();
  endtask

  task automatic sendBit(input logic b);
    sda_in = b; tick();
    rising_edge = 1'b1; tick(); rising_edge = 1'b0; tick();
    falling_edge = 1'b1; tick(); falling_edge = 1'b0; tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
  endtask

  task automatic readByte(output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rising_edge = 1'b1; tick(); rising_edge = 1'b0;
      got = {got[6:0], (sda_oe ? sda_out : 1'b1)};
      tick();
      falling_edge = 1'b1; tick(); falling_edge = 1'b0; tick();
    end
  endtask

  // pulled reports whether the slave was pulling SDA low during ack_check.
  task automatic ackPhase(input logic masterSda, output logic pulled);
    byte_received = 1'b1; ack_prep = 1'b1; tick(); tick();
    ack_prep = 1'b0; ack_check = 1'b1; sda_in = masterSda; tick();
    pulled = sda_oe && !sda_out;
    tick();
    ack_check = 1'b0; ack_done = 1'b1; tick();
    ack_done = 1'b0; byte_received = 1'b0; sda_in = 1'b1; tick();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic pulled;
    sendStart();
    rxValidCnt = 0;
    oeEver = 1'b0;
    sendByte(v.addrByte);
    ackPhase(1'b1, pulled);
    checkOutput($sformatf("v%0d addr ack", idx), 32'(pulled), 32'(v.expAddrAck));
    if (v.expAddrAck) begin
      rx_full = v.full;
      sendByte(v.dataByte);
      ackPhase(1'b1, pulled);
      rx_full = 1'b0;
      checkOutput($sformatf("v%0d data ack", idx), 32'(pulled), 32'(v.expDataAck));
    end
    checkOutput($sformatf("v%0d rx_valid count", idx), 32'(rxValidCnt), 32'(v.expValid));
    checkOutput($sformatf("v%0d rx_data", idx), 32'(rx_data), 32'(v.expRxData));
    checkOutput($sformatf("v%0d state", idx), 32'(dut.state_q), 32'(v.expState));
    checkOutput($sformatf("v%0d sda_oe ever", idx), 32'(oeEver), 32'(v.expAddrAck));
    sendStop();
    checkOutput($sformatf("v%0d idle after stop", idx), 32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    logic       pulled;
    logic [7:0] got;

    vecs[0] = '{8'h54, 8'hA5, 1'b0, 1'b1, 1'b1, 1, 8'hA5, DATA_RX};
    vecs[1] = '{8'h56, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'hA5, WAIT_STOP};
    vecs[2] = '{8'h54, 8'h3C, 1'b1, 1'b1, 1'b0, 0, 8'hA5, WAIT_STOP};
    vecs[3] = '{8'h54, 8'h00, 1'b0, 1'b1, 1'b1, 1, 8'h00, DATA_RX};
    vecs[4] = '{8'hD4, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, WAIT_STOP};
    vecs[5] = '{8'h54, 8'hFF, 1'b0, 1'b1, 1'b1, 1, 8'hFF, DATA_RX};

    n_rst = 1'b0; start = 1'b0; stop = 1'b0; rising_edge = 1'b0; falling_edge = 1'b0;
    byte_received = 1'b0; ack_prep = 1'b0; ack_check = 1'b0; ack_done = 1'b0;
    sda_in = 1'b1; rx_full = 1'b0; tx_data = 8'h3C;
    repeat (3) tick();
    checkOutput("reset sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("reset sda_out", 32'(sda_out), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset state", 32'(dut.state_q), 32'(IDLE));
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Read: two bytes of 0x3C, master ACKs the first and NACKs the second.
    sendStart();
    txReqCnt = 0;
    sendByte(8'h55);
    ackPhase(1'b1, pulled);
    checkOutput("read addr ack", 32'(pulled), 32'd1);
    checkOutput("read busy in DATA_TX", 32'(busy), 32'd1);
    readByte(got);
    checkOutput("read byte 1", 32'(got), 32'h3C);
    checkOutput("read released after byte", 32'(sda_oe), 32'd0);
    ackPhase(1'b0, pulled);
    checkOutput("read slave not driving ack", 32'(pulled), 32'd0);
    readByte(got);
    checkOutput("read byte 2", 32'(got), 32'h3C);
    ackPhase(1'b1, pulled);
    checkOutput("read tx_req count", 32'(txReqCnt), 32'd2);
    checkOutput("read state after nack", 32'(dut.state_q), 32'(WAIT_STOP));
    checkOutput("read busy after nack", 32'(busy), 32'd0);
    sendStop();

    // Repeated start after the 4th data bit aborts the byte.
    sendStart();
    sendByte(8'h54);
    ackPhase(1'b1, pulled);
    rxValidCnt = 0;
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    sendStart();
    checkOutput("rstart state", 32'(dut.state_q), 32'(ADDR_RX));
    checkOutput("rstart shift cleared", 32'(dut.rx_shift_q), 32'd0);
    checkOutput("rstart no rx_valid", 32'(rxValidCnt), 32'd0);
    sendByte(8'h54);
    ackPhase(1'b1, pulled);
    checkOutput("rstart readdress ack", 32'(pulled), 32'd1);

    // Start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
    checkOutput("start+stop state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("start+stop busy", 32'(busy), 32'd0);

    // Asynchronous reset while transmitting.
    sendStart();
    sendByte(8'h55);
    ackPhase(1'b1, pulled);
    checkOutput("pre-reset drive", 32'(sda_oe), 32'd1);
    txReqCnt = 0;
    #3 n_rst = 1'b0;
    #1;
    checkOutput("async reset sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("async reset sda_out", 32'(sda_out), 32'd1);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset tx_req", 32'(tx_req), 32'd0);
    checkOutput("async reset rx_data", 32'(rx_data), 32'd0);
    checkOutput("async reset state", 32'(dut.state_q), 32'(IDLE));
    tick();
    n_rst = 1'b1;
    repeat (3) tick();
    checkOutput("post-reset no tx_req", 32'(txReqCnt), 32'd0);
    checkOutput("post-reset idle", 32'(dut.state_q), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
